// File: rtl/tmds_encoder_8b10b.sv
// TMDS channel encoder: 8-bit pixel or 2-bit control symbol in, 10-bit DC-balanced
// character out, two register stages (transition minimisation, then DC balance).
module tmds_encoder_8b10b (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       de_i,
  input  logic [7:0] data_i,
  input  logic [1:0] c_i,
  output logic [9:0] tmds_o
);

  logic [8:0]        qm_d, qm_q;
  logic [3:0]        n1q_d, n1q_q;
  logic              de_d, de_q;
  logic [1:0]        c_d, c_q;
  logic [9:0]        tmds_d, tmds_q;
  logic signed [4:0] cnt_d, cnt_q;

  logic [7:0]        data_s;
  logic [3:0]        n1d_s;
  logic              use_xnor_s;
  logic signed [4:0] n1_s, n0_s, diff_s;

  // Stage 1: pick XOR/XNOR chaining and count ones of the chained word.
  always_comb begin
    // Blank data during control periods so undriven pixel inputs cannot leak through.
    data_s = de_i ? data_i : 8'h00;
    n1d_s  = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n1d_s = n1d_s + {3'd0, data_s[i]};
    end
    use_xnor_s = (n1d_s > 4'd4) || ((n1d_s == 4'd4) && (data_s[0] == 1'b0));
    qm_d       = 9'd0;
    qm_d[0]    = data_s[0];
    for (int i = 1; i < 8; i++) begin
      qm_d[i] = use_xnor_s ? ~(qm_d[i-1] ^ data_s[i]) : (qm_d[i-1] ^ data_s[i]);
    end
    qm_d[8] = ~use_xnor_s;
    n1q_d   = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n1q_d = n1q_d + {3'd0, qm_d[i]};
    end
    de_d = de_i;
    c_d  = c_i;
  end

  // Stage 2: control codes, or data with optional inversion to steer running disparity.
  always_comb begin
    n1_s   = $signed({1'b0, n1q_q});
    n0_s   = 5'sd8 - n1_s;
    diff_s = n1_s - n0_s;
    tmds_d = 10'h354;
    cnt_d  = cnt_q;
    if (!de_q) begin
      cnt_d = 5'sd0;
      case (c_q)
        2'b00:   tmds_d = 10'h354;
        2'b01:   tmds_d = 10'h0AB;
        2'b10:   tmds_d = 10'h154;
        2'b11:   tmds_d = 10'h2AB;
        default: tmds_d = 10'h354;
      endcase
    end else if ((cnt_q == 5'sd0) || (n1_s == n0_s)) begin
      tmds_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
      cnt_d  = qm_q[8] ? (cnt_q + diff_s) : (cnt_q - diff_s);
    end else if (((cnt_q > 5'sd0) && (n1_s > n0_s)) || ((cnt_q < 5'sd0) && (n0_s > n1_s))) begin
      tmds_d = {1'b1, qm_q[8], ~qm_q[7:0]};
      cnt_d  = cnt_q + (qm_q[8] ? 5'sd2 : 5'sd0) - diff_s;
    end else begin
      tmds_d = {1'b0, qm_q[8], qm_q[7:0]};
      cnt_d  = cnt_q - (qm_q[8] ? 5'sd0 : 5'sd2) + diff_s;
    end
  end

  // Pipeline and disparity registers with synchronous flush.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      qm_q   <= 9'd0;
      n1q_q  <= 4'd0;
      de_q   <= 1'b0;
      c_q    <= 2'b00;
      tmds_q <= 10'h354;
      cnt_q  <= 5'sd0;
    end else begin
      qm_q   <= qm_d;
      n1q_q  <= n1q_d;
      de_q   <= de_d;
      c_q    <= c_d;
      tmds_q <= tmds_d;
      cnt_q  <= cnt_d;
    end
  end

  assign tmds_o = tmds_q;

endmodule
